jit_pipeline_vec_rx: RTL and testbench

JIT_PIPELINE_VEC_RX -- requirements
Module: jit_pipeline_vec_rx

---
 rtl/jit_pipeline_vec_pkg.sv | 18 +
 rtl/jit_pipeline_vec_rx_if.sv | 25 ++
 rtl/jit_rx_fifo.sv | 59 +++++
 rtl/jit_pipeline_vec_rx.sv | 87 ++++++++
 tb/tb_jit_pipeline_vec_rx.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/jit_pipeline_vec_pkg.sv
// Shared field layout for the jit_pipeline_vec word, used by both receive and transmit sides.
// The integrity rule lives here so both sides agree on what a bad word is.
package jit_pipeline_vec_pkg;

  localparam int BUS_W   = 25;
  localparam int TAG_BIT = 24;
  localparam int DATA_HI = 23;
  localparam int DATA_LO = 8;
  localparam int LO8_HI  = 7;
  localparam int DATA_W  = DATA_HI - DATA_LO + 1;
  localparam int LO8_W   = LO8_HI + 1;

  // A word is bad when its lo8 field does not repeat the low byte of data.
  function automatic logic word_bad(input logic [BUS_W-1:0] w);
    return w[LO8_HI:0] != w[DATA_LO+LO8_W-1:DATA_LO];
  endfunction

endpackage

// File: rtl/jit_pipeline_vec_rx_if.sv
// Producer/consumer handshake bundle for the receive FIFO.
// The slave modport is the receiver's view; master is the view of whoever drives it.
interface jit_pipeline_vec_rx_if;
  import jit_pipeline_vec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BUS_W-1:0]  in_bus;
  logic              out_valid;
  logic              out_ready;
  logic              tag;
  logic [DATA_W-1:0] data;
  logic [LO8_W-1:0]  lo8;

  modport slave (
    input  in_valid, in_bus, out_ready,
    output in_ready, out_valid, tag, data, lo8
  );

  modport master (
    output in_valid, in_bus, out_ready,
    input  in_ready, out_valid, tag, data, lo8
  );

endinterface

// File: rtl/jit_rx_fifo.sv
// Small first-word-fall-through FIFO; the head entry is read asynchronously so it
// is visible the cycle after it is written. Callers must not write when full or read when empty.
module jit_rx_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;

endmodule

// File: rtl/jit_pipeline_vec_rx.sv
// Receive side: checks each accepted word, counts words and failures, and queues
// words (optionally dropping bad ones) in a first-word-fall-through FIFO.
module jit_pipeline_vec_rx
  import jit_pipeline_vec_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DROP_BAD = 0
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  jit_pipeline_vec_rx_if.slave   rx,
  output logic                   err_pulse,
  output logic [7:0]             err_count,
  output logic [15:0]            word_count,
  output logic [$clog2(DEPTH):0] level
);

  logic             push;
  logic             pop;
  logic             bad;
  logic             fifo_wr;
  logic             fifo_full;
  logic             fifo_empty;
  logic [BUS_W-1:0] head;

  logic             err_pulse_reg;
  logic [7:0]       err_count_reg;
  logic [7:0]       err_count_next;
  logic [15:0]      word_count_reg;
  logic [15:0]      word_count_next;

  // Both handshakes depend only on registered occupancy, never on out_ready.
  assign rx.in_ready  = !fifo_full;
  assign rx.out_valid = !fifo_empty;

  assign push    = rx.in_valid && rx.in_ready;
  assign pop     = rx.out_valid && rx.out_ready;
  assign bad     = word_bad(rx.in_bus);
  assign fifo_wr = push && !((DROP_BAD != 0) && bad);

  jit_rx_fifo #(
    .WIDTH (BUS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .srst    (sys_rst),
    .wr_en   (fifo_wr),
    .wr_data (rx.in_bus),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign rx.tag  = head[TAG_BIT];
  assign rx.data = head[DATA_HI:DATA_LO];
  assign rx.lo8  = head[LO8_HI:0];

  always_comb begin
    err_count_next  = err_count_reg;
    word_count_next = word_count_reg;
    if (push) begin
      word_count_next = word_count_reg + 16'd1;
      if (bad && (err_count_reg != 8'hFF)) begin
        err_count_next = err_count_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_pulse_reg  <= 1'b0;
      err_count_reg  <= '0;
      word_count_reg <= '0;
    end else begin
      err_pulse_reg  <= push && bad;
      err_count_reg  <= err_count_next;
      word_count_reg <= word_count_next;
    end
  end

  assign err_pulse  = err_pulse_reg;
  assign err_count  = err_count_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_jit_pipeline_vec_rx.sv
// Drives a keep-bad and a drop-bad receiver with the same stimulus and compares
// both, every cycle, against a queue-based model of the receive rules.
module tb_jit_pipeline_vec_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jit_pipeline_vec_rx_if if0 ();
  jit_pipeline_vec_rx_if if1 ();

  logic        ep0, ep1;
  logic [7:0]  ec0, ec1;
  logic [15:0] wc0, wc1;
  logic [2:0]  lv0, lv1;

  jit_pipeline_vec_rx #(.DEPTH(4), .DROP_BAD(0)) dut0 (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .rx         (if0),
    .err_pulse  (ep0),
    .err_count  (ec0),
    .word_count (wc0),
    .level      (lv0)
  );

  jit_pipeline_vec_rx #(.DEPTH(4), .DROP_BAD(1)) dut1 (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .rx         (if1),
    .err_pulse  (ep1),
    .err_count  (ec1),
    .word_count (wc1),
    .level      (lv1)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: one queue per receiver plus its counters.
  logic [24:0] q0[$];
  logic [24:0] q1[$];
  int          ecnt[2];
  int          wcnt[2];
  logic        epm[2];

  logic [15:0] rd;
  logic [7:0]  rl;

  function automatic logic [24:0] mk(input logic t, input logic [15:0] d, input logic [7:0] l);
    return {t, d, l};
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_one(input int k, input logic [2:0] lv, input logic ir, input logic ov,
                           input logic tg, input logic [15:0] d, input logic [7:0] l,
                           input logic ep, input logic [7:0] ec, input logic [15:0] wc,
                           input int sz, input logic [24:0] head);
    chk("level", k, 32'(lv), 32'(sz));
    chk("in_ready", k, 32'(ir), 32'(sz != 4));
    chk("out_valid", k, 32'(ov), 32'(sz != 0));
    if (sz != 0) begin
      chk("tag", k, 32'(tg), 32'(head[24]));
      chk("data", k, 32'(d), 32'(head[23:8]));
      chk("lo8", k, 32'(l), 32'(head[7:0]));
    end
    chk("err_pulse", k, 32'(ep), 32'(epm[k]));
    chk("err_count", k, 32'(ec), 32'(ecnt[k]));
    chk("word_count", k, 32'(wc), 32'(wcnt[k]));
  endtask

  task automatic check_all();
    check_one(0, lv0, if0.in_ready, if0.out_valid, if0.tag, if0.data, if0.lo8, ep0, ec0, wc0,
              q0.size(), (q0.size() != 0) ? q0[0] : 25'd0);
    check_one(1, lv1, if1.in_ready, if1.out_valid, if1.tag, if1.data, if1.lo8, ep1, ec1, wc1,
              q1.size(), (q1.size() != 0) ? q1[0] : 25'd0);
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input logic v, input logic [24:0] b, input logic ordy, input logic r);
    for (int k = 0; k < 2; k++) begin
      int   sz;
      logic push, bad, pop;
      sz = (k == 0) ? q0.size() : q1.size();
      if (r) begin
        if (k == 0) q0.delete(); else q1.delete();
        ecnt[k] = 0;
        wcnt[k] = 0;
        epm[k]  = 1'b0;
      end else begin
        push = v && (sz < 4);
        bad  = (b[7:0] != b[15:8]);
        pop  = (sz > 0) && ordy;
        if (pop) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (push && !(k == 1 && bad)) begin
          if (k == 0) q0.push_back(b); else q1.push_back(b);
        end
        epm[k] = push && bad;
        if (push) wcnt[k] = (wcnt[k] + 1) % 65536;
        if (push && bad && ecnt[k] < 255) ecnt[k]++;
      end
    end
  endtask

  task automatic step(input logic v, input logic [24:0] b, input logic ordy, input logic r);
    @(negedge clk);
    rst           = r;
    if0.in_valid  = v;
    if1.in_valid  = v;
    if0.in_bus    = b;
    if1.in_bus    = b;
    if0.out_ready = ordy;
    if1.out_ready = ordy;
    #1;
    check_all();
    model_edge(v, b, ordy, r);
  endtask

  initial begin
    rst           = 1'b1;
    if0.in_valid  = 1'b0;
    if1.in_valid  = 1'b0;
    if0.in_bus    = '0;
    if1.in_bus    = '0;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    ecnt[0] = 0; ecnt[1] = 0;
    wcnt[0] = 0; wcnt[1] = 0;
    epm[0]  = 1'b0; epm[1] = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held: empty and ready.
    step(1'b0, 25'd0, 1'b0, 1'b1);
    step(1'b1, mk(1'b1, 16'h5555, 8'h55), 1'b1, 1'b1);

    // Good word, then a bad word, then let both drain.
    step(1'b1, mk(1'b1, 16'h1234, 8'h34), 1'b1, 1'b0);
    step(1'b0, 25'd0, 1'b0, 1'b0);
    step(1'b1, mk(1'b0, 16'hABCD, 8'h00), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 25'd0, 1'b1, 1'b0);

    // Fill to DEPTH with out_ready low, offer a fifth word, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, mk(1'b0, 16'(i), 8'(i)), 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 16'h0005, 8'h05), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 25'd0, 1'b1, 1'b0);

    // Hold level at 2 while streaming for 10 cycles.
    for (int i = 0; i < 2; i++) step(1'b1, mk(1'b0, 16'(16'h100 + i), 8'(i)), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, mk(i[0], 16'(16'h200 + i), 8'(i)), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 25'd0, 1'b1, 1'b0);

    // Random traffic, roughly a quarter of words bad.
    for (int i = 0; i < 200; i++) begin
      rd = 16'($urandom);
      rl = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rd[7:0];
      step(1'($urandom_range(0, 1)), mk(1'($urandom), rd, rl), ($urandom_range(0, 2) != 0), 1'b0);
    end

    // Reach level 3, then reset with push and pop active.
    for (int i = 0; i < 5; i++) step(1'b0, 25'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, mk(1'b1, 16'(16'h300 + i), 8'(i)), 1'b0, 1'b0);
    step(1'b1, mk(1'b0, 16'h0777, 8'h77), 1'b1, 1'b1);
    step(1'b0, 25'd0, 1'b0, 1'b0);

    // 300 failing words: err_count saturates, word_count keeps going.
    step(1'b0, 25'd0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      rd = 16'($urandom);
      step(1'b1, mk(1'b0, rd, ~rd[7:0]), 1'b1, 1'b0);
    end
    step(1'b0, 25'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check_all();
    chk("err_count_saturated", 0, 32'(ec0), 32'd255);
    chk("word_count_300", 0, 32'(wc0), 32'd300);
    chk("err_count_saturated", 1, 32'(ec1), 32'd255);
    chk("level_after_drops", 1, 32'(lv1), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
